div_ctrl: RTL and testbench

- Sequencing controller between the EX-stage ALU and the multi-cycle radix-2 divider (`div`).
- Captures operands once per DIV/DIVU instruction and holds `div_start`/sign stable for the whole operation.
- Drives the pipeline stall, handles flush/cancel, and short-circuits divide-by-zero.
- Holds the 64-bit {hi,lo} result until the pipeline consumes it, so a still-asserted request never relaunches the same instruction.

---
 rtl/div_ctrl_pkg.sv | 20 ++
 rtl/div_ctrl.sv | 145 ++++++++++++++
 tb/tb_div_ctrl.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_ctrl_pkg.sv
// div_ctrl_pkg: shared types and constants for the divider sequencing controller.
//   - dc_state_e : controller FSM state encoding (2 bits)
//   - DivStart / DivStop : levels driven on the divider start line
//   - DzeroQuot : quotient reported for a divide-by-zero
package div_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StBusy  = 2'd1,
        StDzero = 2'd2,
        StDone  = 2'd3
    } dc_state_e;

    localparam logic DivStart = 1'b1;
    localparam logic DivStop  = 1'b0;

    // Divide-by-zero yields an all-ones quotient regardless of signedness.
    localparam logic [31:0] DzeroQuot = 32'hFFFF_FFFF;

endpackage

// File: rtl/div_ctrl.sv
// div_ctrl: sequencing controller between the EX-stage ALU and a multi-cycle divider.
// Captures operands once per DIV/DIVU, holds start/sign/operands stable while the divider
// runs, stalls the pipeline, handles flush, short-circuits divide-by-zero, and holds the
// {hi,lo} result until the pipeline advances.
// Ports:
//   i_clk, i_rst          core clock, synchronous active-high reset
//   i_req, i_req_signed   EX holds a divide op; 1 = signed
//   i_opa, i_opb          dividend, divisor
//   i_flush, i_advance    EX flush; EX advances this cycle
//   o_stall               pipeline stall request (combinational)
//   o_result(_valid)      {remainder, quotient} and its valid flag
//   o_wdog_err            one-cycle pulse on watchdog abort
//   o_div_*               divider interface: start, sign, operands, annul
//   i_div_result/_ready   divider result and one-cycle ready pulse
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int unsigned DivCycles = 34,
    parameter bit          WdogEn    = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req,
    input  logic        i_req_signed,
    input  logic [31:0] i_opa,
    input  logic [31:0] i_opb,
    input  logic        i_flush,
    input  logic        i_advance,
    output logic        o_stall,
    output logic [63:0] o_result,
    output logic        o_result_valid,
    output logic        o_wdog_err,
    output logic        o_div_start,
    output logic        o_div_sign,
    output logic [31:0] o_div_a,
    output logic [31:0] o_div_b,
    output logic        o_div_annul,
    input  logic [63:0] i_div_result,
    input  logic        i_div_ready
);

    localparam int unsigned WdogLimit = DivCycles + 2;
    localparam int unsigned CntW      = $clog2(WdogLimit + 1);

    dc_state_e        r_state;
    logic [CntW-1:0]  r_wdog_cnt;
    logic [63:0]      r_result;
    logic             r_result_valid;
    logic             r_wdog_err;
    logic             r_div_start;
    logic             r_div_sign;
    logic [31:0]      r_div_a;
    logic [31:0]      r_div_b;
    logic             r_div_annul;
    logic             w_wdog_hit;

    assign w_wdog_hit = WdogEn && (r_wdog_cnt == CntW'(WdogLimit));

    // Stall is held off in DONE so the pipeline can consume the held result.
    assign o_stall = i_req && !i_flush && (r_state != StDone);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= StIdle;
            r_wdog_cnt     <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_wdog_err     <= 1'b0;
            r_div_start    <= DivStop;
            r_div_sign     <= 1'b0;
            r_div_a        <= '0;
            r_div_b        <= '0;
            r_div_annul    <= 1'b0;
        end else begin
            // Pulses default low every cycle.
            r_div_annul <= 1'b0;
            r_wdog_err  <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (i_req && !i_flush) begin
                        r_div_a    <= i_opa;
                        r_div_b    <= i_opb;
                        r_div_sign <= i_req_signed;
                        r_wdog_cnt <= '0;
                        if (i_opb == '0) begin
                            r_state <= StDzero;
                        end else begin
                            r_state     <= StBusy;
                            r_div_start <= DivStart;
                        end
                    end
                end
                StBusy: begin
                    // Flush beats ready, ready beats the watchdog.
                    if (i_flush) begin
                        r_div_annul <= 1'b1;
                        r_div_start <= DivStop;
                        r_state     <= StIdle;
                    end else if (i_div_ready) begin
                        r_result       <= i_div_result;
                        r_result_valid <= 1'b1;
                        r_div_start    <= DivStop;
                        r_state        <= StDone;
                    end else if (w_wdog_hit) begin
                        r_div_annul    <= 1'b1;
                        r_wdog_err     <= 1'b1;
                        r_result       <= '0;
                        r_result_valid <= 1'b1;
                        r_div_start    <= DivStop;
                        r_state        <= StDone;
                    end else begin
                        r_wdog_cnt <= r_wdog_cnt + CntW'(1);
                    end
                end
                StDzero: begin
                    if (i_flush) begin
                        r_state <= StIdle;
                    end else begin
                        r_result       <= {r_div_a, DzeroQuot};
                        r_result_valid <= 1'b1;
                        r_state        <= StDone;
                    end
                end
                StDone: begin
                    // A still-high req without advance just keeps the result parked.
                    if (i_flush || i_advance) begin
                        r_result_valid <= 1'b0;
                        r_state        <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_result       = r_result;
    assign o_result_valid = r_result_valid;
    assign o_wdog_err     = r_wdog_err;
    assign o_div_start    = r_div_start;
    assign o_div_sign     = r_div_sign;
    assign o_div_a        = r_div_a;
    assign o_div_b        = r_div_b;
    assign o_div_annul    = r_div_annul;

endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: self-checking bench for div_ctrl with a behavioural divider model and an
// arithmetic reference for quotient/remainder.
module tb_div_ctrl;

    localparam int unsigned DivCycles = 34;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        req_signed = 1'b0;
    logic [31:0] opa = '0;
    logic [31:0] opb = '0;
    logic        flush = 1'b0;
    logic        advance = 1'b0;
    logic [63:0] div_result = '0;
    logic        div_ready = 1'b0;

    logic        o_stall;
    logic [63:0] o_result;
    logic        o_result_valid;
    logic        o_wdog_err;
    logic        o_div_start;
    logic        o_div_sign;
    logic [31:0] o_div_a;
    logic [31:0] o_div_b;
    logic        o_div_annul;

    always #5 clk = ~clk;

    div_ctrl #(
        .DivCycles (DivCycles),
        .WdogEn    (1'b1)
    ) u_dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_req          (req),
        .i_req_signed   (req_signed),
        .i_opa          (opa),
        .i_opb          (opb),
        .i_flush        (flush),
        .i_advance      (advance),
        .o_stall        (o_stall),
        .o_result       (o_result),
        .o_result_valid (o_result_valid),
        .o_wdog_err     (o_wdog_err),
        .o_div_start    (o_div_start),
        .o_div_sign     (o_div_sign),
        .o_div_a        (o_div_a),
        .o_div_b        (o_div_b),
        .o_div_annul    (o_div_annul),
        .i_div_result   (div_result),
        .i_div_ready    (div_ready)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: {remainder, quotient}; divide-by-zero gives {dividend, all ones}.
    function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a,
                                            input logic [31:0] b);
        int q;
        int r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (s) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
            return {32'(r), 32'(q)};
        end
        return {a % b, a / b};
    endfunction

    // Divider model: ready pulses in the model_lat-th cycle that start is seen high.
    int          model_lat  = 1;
    bit          model_hang = 1'b0;
    int          model_cnt  = 0;
    int          launches   = 0;
    int          hold_err   = 0;
    int          busy_cycles = 0;
    logic        prev_start = 1'b0;
    logic [31:0] seen_a = '0;
    logic [31:0] seen_b = '0;

    always @(negedge clk) begin
        if (o_div_start) begin
            if (!prev_start) begin
                launches++;
                seen_a    = o_div_a;
                seen_b    = o_div_b;
                model_cnt = 0;
            end else if (o_div_a !== seen_a || o_div_b !== seen_b) begin
                hold_err++;
            end
            model_cnt++;
            busy_cycles++;
            if (!model_hang && model_cnt == model_lat) begin
                div_ready  = 1'b1;
                div_result = ref_div(o_div_sign, o_div_a, o_div_b);
            end else begin
                div_ready  = 1'b0;
                div_result = {$urandom, $urandom};
            end
        end else begin
            model_cnt  = 0;
            div_ready  = 1'b0;
            div_result = {$urandom, $urandom};
        end
        prev_start = o_div_start;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic release_done();
        advance = 1'b1;
        tick();
        advance = 1'b0;
        req     = 1'b0;
        check("released_valid", o_result_valid, 1'b0);
    endtask

    task automatic do_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                         input int lat, input int hold);
        logic [63:0] exp;
        int          cyc;
        bit          seen;
        int          stall_gap;
        exp        = ref_div(s, a, b);
        model_lat  = lat;
        model_hang = 1'b0;
        launches   = 0;
        hold_err   = 0;
        req        = 1'b1;
        req_signed = s;
        opa        = a;
        opb        = b;
        cyc        = 0;
        seen       = 1'b0;
        stall_gap  = 0;
        while (cyc < 200 && !seen) begin
            tick();
            cyc++;
            if (o_result_valid) seen = 1'b1;
            else if (!o_stall) stall_gap++;
        end
        check("done_seen", seen, 1'b1);
        check("stall_held", stall_gap, 0);
        check("latency", cyc, (b == 32'd0) ? 2 : lat + 1);
        check("result", o_result, exp);
        check("stall_done", o_stall, 1'b0);
        repeat (hold) tick();
        check("hold_valid", o_result_valid, 1'b1);
        check("hold_result", o_result, exp);
        check("launches", launches, (b == 32'd0) ? 0 : 1);
        check("operand_hold", hold_err, 0);
        release_done();
    endtask

    initial begin
        int          cyc;
        bit          seen;
        logic        s;
        logic [31:0] a;
        logic [31:0] b;

        // Reset
        rst = 1'b1;
        tick();
        tick();
        check("rst_result", o_result, 64'd0);
        check("rst_ctl", {o_result_valid, o_wdog_err, o_div_start, o_div_sign, o_div_annul},
              5'd0);
        check("rst_ops", {o_div_a, o_div_b}, 64'd0);
        rst = 1'b0;
        tick();

        // Directed cases
        do_op(1'b1, 32'hFFFF_FFF9, 32'd2, 10, 0);
        do_op(1'b0, 32'hFFFF_FFFF, 32'd16, 7, 3);
        do_op(1'b0, 32'h0000_1234, 32'd0, 1, 1);

        // Flush in the 5th BUSY cycle
        model_lat = 20;
        req = 1'b1; req_signed = 1'b1; opa = 32'd100; opb = 32'd7;
        repeat (5) tick();
        check("flush_pre_start", o_div_start, 1'b1);
        flush = 1'b1;
        tick();
        check("flush_annul", o_div_annul, 1'b1);
        check("flush_start", o_div_start, 1'b0);
        check("flush_valid", o_result_valid, 1'b0);
        flush = 1'b0;
        req   = 1'b0;
        tick();
        check("flush_annul_pulse", o_div_annul, 1'b0);
        check("flush_idle_valid", o_result_valid, 1'b0);
        do_op(1'b1, 32'hFFFF_FF9C, 32'd7, 5, 0);

        // Watchdog: divider never answers
        model_hang  = 1'b1;
        busy_cycles = 0;
        req = 1'b1; req_signed = 1'b0; opa = 32'd50; opb = 32'd3;
        cyc = 0; seen = 1'b0;
        while (cyc < 200 && !seen) begin
            tick();
            cyc++;
            if (o_wdog_err) seen = 1'b1;
        end
        check("wdog_seen", seen, 1'b1);
        check("wdog_busy_cycles", busy_cycles, DivCycles + 3);
        check("wdog_annul", o_div_annul, 1'b1);
        check("wdog_result", o_result, 64'd0);
        check("wdog_valid", o_result_valid, 1'b1);
        check("wdog_stall", o_stall, 1'b0);
        tick();
        check("wdog_pulse", o_wdog_err, 1'b0);
        model_hang = 1'b0;
        release_done();

        // Reset mid-BUSY
        model_lat = 30;
        req = 1'b1; req_signed = 1'b1; opa = 32'd999; opb = 32'd11;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        check("mrst_ctl", {o_result_valid, o_wdog_err, o_div_start, o_div_sign, o_div_annul},
              5'd0);
        check("mrst_ops", {o_div_a, o_div_b}, 64'd0);
        check("mrst_result", o_result, 64'd0);
        rst = 1'b0;
        req = 1'b0;
        tick();

        // Flush coincident with div_ready
        model_lat = 6;
        req = 1'b1; req_signed = 1'b0; opa = 32'd77; opb = 32'd5;
        cyc = 0; seen = 1'b0;
        while (cyc < 50 && !seen) begin
            tick();
            cyc++;
            if (div_ready) seen = 1'b1;
        end
        check("fr_ready_seen", seen, 1'b1);
        flush = 1'b1;
        tick();
        check("fr_valid", o_result_valid, 1'b0);
        check("fr_annul", o_div_annul, 1'b1);
        check("fr_start", o_div_start, 1'b0);
        flush = 1'b0;
        req   = 1'b0;
        tick();
        check("fr_valid_after", o_result_valid, 1'b0);

        // Randomized ops
        for (int i = 0; i < 12; i++) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 16));
                default: b = $urandom;
            endcase
            if (b == 32'd0 && $urandom_range(0, 1) == 0) b = 32'd3;
            if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd2;
            do_op(s, a, b, int'($urandom_range(1, DivCycles)), int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
